// File: rtl/mem_pkg.sv
// Shared types and limits for the synchronous word memory.
package mem_pkg;
  typedef enum logic {MEM_INIT, MEM_RUN} mem_state_e;
  localparam int MAX_READ_LAT = 4;
endpackage

// File: rtl/mem_rsp_pipe.sv
// Fixed-latency response shift register; stage 0 loads at the accept edge.
module mem_rsp_pipe #(
  parameter int W   = 17,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data
);
  logic [LAT:1]            vld_pipe;
  logic [LAT-1:0][W-1:0]   dat_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= in_vld;
      dat_pipe[0] <= in_data;
      for (int i = 2; i <= LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      for (int i = 1; i < LAT; i++)  dat_pipe[i] <= dat_pipe[i-1];
    end
  end

  assign out_vld  = vld_pipe[LAT];
  assign out_data = dat_pipe[LAT-1];
endmodule

// File: rtl/sync_memory.sv
// Single-port word memory: clear sweep after reset, valid/ready requests,
// byte-enable writes, range-checked addresses, fixed-latency in-order responses.
module sync_memory
  import mem_pkg::*;
#(
  parameter int              DATA_W   = 16,
  parameter int              DEPTH    = 500,
  parameter int              ADDR_W   = 16,
  parameter int              READ_LAT = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                init_done
);
  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // one extra bit so DEPTH == 2**ADDR_W does not wrap to 0
  localparam logic [ADDR_W:0]  DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH - 1);

  typedef struct packed {
    logic              valid;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

  if (DATA_W < 8 || DATA_W % 8 != 0) begin : g_bad_data_w
    $error("sync_memory: DATA_W must be a positive multiple of 8");
  end
  if (DEPTH < 1 || ADDR_W < IDX_W || ADDR_W > 31) begin : g_bad_addr_w
    $error("sync_memory: ADDR_W too narrow for DEPTH");
  end
  if (READ_LAT < 1 || READ_LAT > MAX_READ_LAT) begin : g_bad_lat
    $error("sync_memory: READ_LAT out of range");
  end

  mem_state_e        state, state_nx;
  logic [IDX_W-1:0]  cnt;
  logic [DATA_W-1:0] words [DEPTH];

  logic              accept, in_range;
  logic [IDX_W-1:0]  idx;
  rsp_t              rsp_in, rsp_out;

  assign accept   = req_valid && req_ready;
  assign in_range = {1'b0, req_addr} < DEPTH_X;
  assign idx      = req_addr[IDX_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= MEM_INIT;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    init_done = 1'b0;
    case (state)
      MEM_INIT: if (cnt == LAST) state_nx = MEM_RUN;
      MEM_RUN: begin
        req_ready = 1'b1;
        init_done = 1'b1;
      end
      default: state_nx = MEM_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  cnt <= '0;
    else if (state == MEM_INIT) cnt <= cnt + 1'b1;
  end

  // array has no reset; the sweep owns it until RUN
  always_ff @(posedge clk) begin
    if (state == MEM_INIT) begin
      words[cnt] <= INIT_VAL;
    end else if (accept && req_we && in_range) begin
      for (int b = 0; b < BE_W; b++)
        if (req_be[b]) words[idx][8*b +: 8] <= req_wdata[8*b +: 8];
    end
  end

  always_comb begin
    rsp_in       = '0;
    rsp_in.valid = accept;
    rsp_in.err   = accept && !in_range;
    if (accept && !req_we && in_range) rsp_in.rdata = words[idx];
  end

  mem_rsp_pipe #(.W(DATA_W + 1), .LAT(READ_LAT)) u_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_vld   (rsp_in.valid),
    .in_data  ({rsp_in.err, rsp_in.rdata}),
    .out_vld  (rsp_out.valid),
    .out_data ({rsp_out.err, rsp_out.rdata})
  );

  assign rsp_valid = rsp_out.valid;
  assign rsp_err   = rsp_out.err;
  assign rsp_rdata = rsp_out.rdata;
endmodule
